// File: rtl/sargantana_icache_pkg.sv
// Shared types and constants for the Sargantana icache miss-status holding registers.
// Entry layout is sized for the default 40-bit physical address, 4-way icache.
package sargantana_icache_pkg;

  localparam int unsigned ICACHE_LINE_OFFSET = 6;
  localparam int unsigned ICACHE_PADDR_WIDTH = 40;
  localparam int unsigned ICACHE_N_WAY       = 4;
  localparam int unsigned ICACHE_LINE_ADDR_W = ICACHE_PADDR_WIDTH - ICACHE_LINE_OFFSET;
  localparam int unsigned ICACHE_WAY_W       = $clog2(ICACHE_N_WAY);

  typedef enum logic [1:0] {
    MSHR_FREE      = 2'd0,
    MSHR_WAIT_REQ  = 2'd1,
    MSHR_WAIT_RESP = 2'd2
  } mshr_state_t;

  typedef struct packed {
    mshr_state_t                   state;
    logic [ICACHE_LINE_ADDR_W-1:0] line;
    logic [ICACHE_WAY_W-1:0]       way;
    logic                          stale;
    logic                          killed;
  } mshr_entry_t;

  localparam mshr_entry_t MSHR_ENTRY_RESET = '{
    state:  MSHR_FREE,
    line:   '0,
    way:    '0,
    stale:  1'b0,
    killed: 1'b0
  };

  // A stale line is never marked valid; a killed one only when the design keeps killed fills.
  function automatic logic mshr_fill_valid_bit(input logic stale, input logic killed,
                                               input logic keep_killed);
    return !stale && (!killed || keep_killed);
  endfunction

endpackage

// File: rtl/sargantana_icache_prio_enc.sv
// Lowest-index priority encoder: isolates the lowest set request bit and returns its index.
// Shared by the entry allocator and the fill-request issuer.
module sargantana_icache_prio_enc #(
  parameter int unsigned N = 4,
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  logic [N-1:0] onehot_s;

  // Isolate the lowest set bit, then fold it into a binary index.
  always_comb begin
    onehot_s = req_i & (~req_i + N'(1));
    idx_o    = '0;
    for (int i = 0; i < int'(N); i++) begin
      idx_o = idx_o | (onehot_s[i] ? IDX_W'(i) : IDX_W'(0));
    end
    valid_o = |req_i;
  end

endmodule

// File: rtl/sargantana_icache_mshr.sv
// Multi-entry icache miss tracker: allocates/merges misses, issues tagged fills to the upper level,
// filters stale or killed fills and produces one registered line write per accepted response.
module sargantana_icache_mshr
  import sargantana_icache_pkg::*;
#(
  parameter int unsigned N_MSHR      = 4,
  parameter int unsigned PADDR_WIDTH = 40,
  parameter int unsigned LINE_WIDTH  = 512,
  parameter int unsigned N_WAY       = 4,
  parameter int unsigned KEEP_KILLED = 1,
  localparam int unsigned ID_W  = $clog2(N_MSHR),
  localparam int unsigned WAY_W = $clog2(N_WAY)
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   flush_i,
  input  logic                   kill_i,
  input  logic                   miss_valid_i,
  input  logic [PADDR_WIDTH-1:0] miss_paddr_i,
  input  logic [WAY_W-1:0]       miss_way_i,
  output logic                   miss_ready_o,
  output logic                   miss_merged_o,
  output logic                   ifill_req_valid_o,
  input  logic                   ifill_req_ready_i,
  output logic [PADDR_WIDTH-1:0] ifill_req_paddr_o,
  output logic [WAY_W-1:0]       ifill_req_way_o,
  output logic [ID_W-1:0]        ifill_req_id_o,
  input  logic                   ifill_resp_valid_i,
  input  logic [ID_W-1:0]        ifill_resp_id_i,
  input  logic [LINE_WIDTH-1:0]  ifill_resp_data_i,
  input  logic                   inv_valid_i,
  input  logic [PADDR_WIDTH-1:0] inv_paddr_i,
  output logic                   fill_valid_o,
  output logic [PADDR_WIDTH-1:0] fill_paddr_o,
  output logic [WAY_W-1:0]       fill_way_o,
  output logic [LINE_WIDTH-1:0]  fill_data_o,
  output logic                   fill_valid_bit_o,
  output logic                   busy_o,
  output logic                   protocol_err_o
);

  localparam int unsigned LADDR_W = PADDR_WIDTH - ICACHE_LINE_OFFSET;

  mshr_entry_t                   entries_r     [N_MSHR];
  mshr_entry_t                   entries_nxt_s [N_MSHR];
  mshr_entry_t                   resp_entry_s;
  logic [N_MSHR-1:0]             free_s, wait_req_s, match_s, freeing_s, inv_hit_s;
  logic [ICACHE_LINE_ADDR_W-1:0] line_s, inv_line_s;
  logic                          resp_hit_s, alloc_s, alloc_vld_s, issue_vld_s, req_fire_s;
  logic [ID_W-1:0]               alloc_idx_s, issue_idx_s, issue_id_s, lock_id_r;
  logic                          lock_r;
  logic                          fill_valid_r, fill_valid_bit_r, protocol_err_r;
  logic [PADDR_WIDTH-1:0]        fill_paddr_r;
  logic [WAY_W-1:0]              fill_way_r;
  logic [LINE_WIDTH-1:0]         fill_data_r;
  logic                          unused_offset_s;

  assign unused_offset_s = ^{miss_paddr_i[ICACHE_LINE_OFFSET-1:0], inv_paddr_i[ICACHE_LINE_OFFSET-1:0]};

  sargantana_icache_prio_enc #(.N(N_MSHR)) u_alloc_enc (
    .req_i   (free_s),
    .idx_o   (alloc_idx_s),
    .valid_o (alloc_vld_s)
  );

  sargantana_icache_prio_enc #(.N(N_MSHR)) u_issue_enc (
    .req_i   (wait_req_s),
    .idx_o   (issue_idx_s),
    .valid_o (issue_vld_s)
  );

  // Per-entry status: free/waiting vectors, response decode, miss and invalidation line matches.
  always_comb begin
    line_s     = ICACHE_LINE_ADDR_W'(miss_paddr_i[PADDR_WIDTH-1:ICACHE_LINE_OFFSET]);
    inv_line_s = ICACHE_LINE_ADDR_W'(inv_paddr_i[PADDR_WIDTH-1:ICACHE_LINE_OFFSET]);
    resp_entry_s = entries_r[ifill_resp_id_i];
    if (ifill_resp_valid_i && (int'(ifill_resp_id_i) < int'(N_MSHR))) begin
      resp_hit_s = (resp_entry_s.state == MSHR_WAIT_RESP);
    end else begin
      resp_hit_s = 1'b0;
    end
    for (int i = 0; i < int'(N_MSHR); i++) begin
      free_s[i]     = (entries_r[i].state == MSHR_FREE);
      wait_req_s[i] = (entries_r[i].state == MSHR_WAIT_REQ);
      freeing_s[i]  = resp_hit_s && (ifill_resp_id_i == ID_W'(i));
      match_s[i]    = !free_s[i] && (entries_r[i].line == line_s) && !freeing_s[i];
      inv_hit_s[i]  = inv_valid_i && !free_s[i] && (entries_r[i].line == inv_line_s);
    end
  end

  // Miss acceptance; the issue slot stays locked on one entry while the upper level back-pressures.
  always_comb begin
    miss_ready_o  = !flush_i && ((|match_s) || alloc_vld_s);
    miss_merged_o = miss_valid_i && !flush_i && (|match_s);
    alloc_s       = miss_valid_i && miss_ready_o && !(|match_s);
    if (lock_r) begin
      issue_id_s = lock_id_r;
    end else begin
      issue_id_s = issue_idx_s;
    end
    ifill_req_valid_o = lock_r || issue_vld_s;
    ifill_req_id_o    = issue_id_s;
    ifill_req_paddr_o = {LADDR_W'(entries_r[issue_id_s].line), {ICACHE_LINE_OFFSET{1'b0}}};
    ifill_req_way_o   = WAY_W'(entries_r[issue_id_s].way);
    req_fire_s        = ifill_req_valid_o && ifill_req_ready_i;
    busy_o            = !(&free_s);
  end

  // Entry next-state: allocate, issue, retire on response, accumulate stale/killed flags.
  always_comb begin
    for (int i = 0; i < int'(N_MSHR); i++) begin
      entries_nxt_s[i] = entries_r[i];
      case (entries_r[i].state)
        MSHR_FREE: begin
          if (alloc_s && (alloc_idx_s == ID_W'(i))) begin
            entries_nxt_s[i] = '{state: MSHR_WAIT_REQ, line: line_s,
                                 way: ICACHE_WAY_W'(miss_way_i), stale: 1'b0, killed: 1'b0};
          end else begin
            entries_nxt_s[i] = MSHR_ENTRY_RESET;
          end
        end
        MSHR_WAIT_REQ: begin
          if (req_fire_s && (issue_id_s == ID_W'(i))) begin
            entries_nxt_s[i].state = MSHR_WAIT_RESP;
          end else begin
            entries_nxt_s[i].state = MSHR_WAIT_REQ;
          end
          entries_nxt_s[i].stale  = entries_r[i].stale | flush_i | inv_hit_s[i];
          entries_nxt_s[i].killed = entries_r[i].killed | kill_i;
        end
        MSHR_WAIT_RESP: begin
          if (freeing_s[i]) begin
            entries_nxt_s[i] = MSHR_ENTRY_RESET;
          end else begin
            entries_nxt_s[i].stale  = entries_r[i].stale | flush_i | inv_hit_s[i];
            entries_nxt_s[i].killed = entries_r[i].killed | kill_i;
          end
        end
        default: entries_nxt_s[i] = MSHR_ENTRY_RESET;
      endcase
    end
  end

  // Entry state registers and issue lock.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < int'(N_MSHR); i++) begin
        entries_r[i] <= MSHR_ENTRY_RESET;
      end
      lock_r    <= 1'b0;
      lock_id_r <= '0;
    end else begin
      entries_r <= entries_nxt_s;
      lock_r    <= ifill_req_valid_o && !ifill_req_ready_i;
      lock_id_r <= issue_id_s;
    end
  end

  // Registered line write; flags raised in the response cycle itself also poison the fill.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      fill_valid_r     <= 1'b0;
      fill_paddr_r     <= '0;
      fill_way_r       <= '0;
      fill_data_r      <= '0;
      fill_valid_bit_r <= 1'b0;
      protocol_err_r   <= 1'b0;
    end else begin
      fill_valid_r   <= resp_hit_s;
      protocol_err_r <= protocol_err_r | (ifill_resp_valid_i & ~resp_hit_s);
      if (resp_hit_s) begin
        fill_paddr_r     <= {LADDR_W'(resp_entry_s.line), {ICACHE_LINE_OFFSET{1'b0}}};
        fill_way_r       <= WAY_W'(resp_entry_s.way);
        fill_data_r      <= ifill_resp_data_i;
        fill_valid_bit_r <= mshr_fill_valid_bit(
                              resp_entry_s.stale | flush_i | inv_hit_s[ifill_resp_id_i],
                              resp_entry_s.killed | kill_i, KEEP_KILLED != 0);
      end
    end
  end

  assign fill_valid_o     = fill_valid_r;
  assign fill_paddr_o     = fill_paddr_r;
  assign fill_way_o       = fill_way_r;
  assign fill_data_o      = fill_data_r;
  assign fill_valid_bit_o = fill_valid_bit_r;
  assign protocol_err_o   = protocol_err_r;

endmodule
